instruction_fetcher: RTL and testbench
======================================

Name: instruction_fetcher

Overview:
Front-end fetch stage. Owns the PC and presents it to the instruction cache every cycle. On a hit it forwards the instruction to the instruction queue; on a miss it fetches the word from the memory controller, refills the cache and re-looks-up. It sits between the instruction cache (downstream lookup/refill), the memory controller, and the decoder's instruction queue.

Parameters:
ADDR_WIDTH, 32, PC and memory address width (matches `ADDR_TYPE).
INST_WIDTH, 32, instruction word width (matches `INST_TYPE).
RESET_PC, 32'h0, PC value loaded at reset.

Ports:
clk_in  in  1  clock, all state on rising edge
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global ready; 0 freezes all state
clr_in  in  1  pipeline flush / redirect (mispredict, exception)
clr_pc  in  ADDR_WIDTH  redirect target, sampled when clr_in=1
if_to_ic_inst_addr  out  ADDR_WIDTH  lookup/refill address
if_to_ic_inst  out  INST_WIDTH  refill data
if_to_ic_inst_valid  out  1  refill write strobe, one cycle
if_to_ic_ready  out  1  lookup enable
ic_to_if_hit  in  1  combinational hit for current lookup
ic_to_if_hit_inst  in  INST_WIDTH  hit data
if_to_mc_req  out  1  memory fetch request, level, held until done
if_to_mc_addr  out  ADDR_WIDTH  miss address
mc_to_if_done  in  1  one-cycle completion pulse
mc_to_if_inst  in  INST_WIDTH  fetched word, valid with done
iq_to_if_full  in  1  instruction queue cannot accept this cycle
if_to_iq_valid  out  1  registered, one pulse per instruction
if_to_iq_inst  out  INST_WIDTH  instruction
if_to_iq_pc  out  ADDR_WIDTH  its PC

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=FETCH, miss_addr=0. All outputs are 0 except if_to_ic_inst_addr=RESET_PC. Reset mid-miss abandons the request; if_to_mc_req drops immediately.
- rdy_in=0: no register changes. Outputs hold. mc_to_if_done is ignored, because the memory controller is frozen by the same signal.
- PC is always word aligned. clr_pc[1:0] is forced to 0. Next PC is pc+4, wrapping modulo 2^ADDR_WIDTH. There is no prediction in this block.
- FETCH state:
  - if_to_ic_ready=1 and if_to_ic_inst_addr=pc.
  - Hit and !iq_to_if_full: next cycle if_to_iq_valid=1, inst=ic_to_if_hit_inst, pc=old pc; pc<=pc+4. Sustains one instruction per cycle.
  - Hit and full: no output, pc held.
  - Miss (full or not): miss_addr<=pc, state<=MEM_WAIT.
- MEM_WAIT state:
  - if_to_ic_ready=0, if_to_mc_req=1, if_to_mc_addr=miss_addr.
  - On mc_to_if_done, in the same cycle: if_to_ic_inst_valid=1, if_to_ic_inst_addr=miss_addr, if_to_ic_inst=mc_to_if_inst. State<=FETCH.
  - The next cycle re-looks-up pc, which hits if the PC was not redirected. Miss-to-issue latency is mem latency + 2 cycles.
- if_to_iq_valid is a single-cycle pulse. It is 0 in any cycle with no issue.
- clr_in=1 (priority over all else except reset and rdy):
  - pc<=clr_pc and if_to_iq_valid<=0 next cycle; no issue this cycle.
  - In FETCH: stay in FETCH.
  - In MEM_WAIT: the outstanding request cannot be aborted. Remain in MEM_WAIT; the refill still writes miss_addr (the data is correct), then return to FETCH at the new pc.
  - clr_in coincident with mc_to_if_done: refill is performed and state goes to FETCH with pc=clr_pc.
- if_to_ic_inst_valid is never asserted together with if_to_ic_ready.

Decomposition:
- Shared macro header: `ADDR_TYPE, `INST_TYPE, fetch-state encodings (FETCH=1'b0, MEM_WAIT=1'b1), RESET_PC default.
- Single module. The FSM and PC logic are too small to justify a sub-module.

Test Plan:
- Reset release with cache pre-filled for 0x0..0xC, queue never full -> four consecutive if_to_iq_valid pulses, pc 0x0,0x4,0x8,0xC; first pulse on cycle 2 after reset.
- Cold miss at 0x100, memory done after 5 cycles with 0x00A00093 -> if_to_mc_req held 5 cycles, addr 0x100; one refill strobe; issue pc=0x100, inst=0x00A00093 two cycles after done.
- Hits with iq_to_if_full high for 3 cycles at pc 0x20 -> no valid during stall; 0x20 issued exactly once after release, no duplicate or skip.
- clr_in with clr_pc=0x207 during FETCH -> next lookup addr 0x204; no issue from old stream after the clear cycle.
- clr_in (clr_pc=0x40) during MEM_WAIT for 0x300 -> cache refilled at 0x300, no issue of 0x300, next lookup 0x40.
- rst_in asserted mid-MEM_WAIT -> if_to_mc_req low immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetcher_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package instruction_fetcher_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int INST_WIDTH_DEF = 32;

    typedef enum logic {
        FETCH    = 1'b0,
        MEM_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher.sv
// Front-end fetch stage: owns the PC, looks it up in the I-cache every cycle,
// issues hits to the instruction queue and services misses from memory.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    INST_WIDTH = INST_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic [ADDR_WIDTH-1:0] clr_pc,
    output logic [ADDR_WIDTH-1:0] if_to_ic_inst_addr,
    output logic [INST_WIDTH-1:0] if_to_ic_inst,
    output logic                  if_to_ic_inst_valid,
    output logic                  if_to_ic_ready,
    input  logic                  ic_to_if_hit,
    input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
    output logic                  if_to_mc_req,
    output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
    input  logic                  mc_to_if_done,
    input  logic [INST_WIDTH-1:0] mc_to_if_inst,
    input  logic                  iq_to_if_full,
    output logic                  if_to_iq_valid,
    output logic [INST_WIDTH-1:0] if_to_iq_inst,
    output logic [ADDR_WIDTH-1:0] if_to_iq_pc
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  iq_valid_q, iq_valid_d;
    logic [INST_WIDTH-1:0] iq_inst_q, iq_inst_d;
    logic [ADDR_WIDTH-1:0] iq_pc_q, iq_pc_d;
    logic                  refill_s;
    logic [ADDR_WIDTH-1:0] clr_pc_aligned_s;

    assign clr_pc_aligned_s = clr_pc & ALIGN_MASK;
    // The memory controller is frozen with rdy_in, so done only counts when ready.
    assign refill_s = rdy_in && (state_q == MEM_WAIT) && mc_to_if_done;

    // Cache and memory interface: lookup in FETCH, refill strobe in MEM_WAIT.
    always_comb begin
        if_to_ic_ready      = 1'b0;
        if_to_ic_inst_addr  = pc_q;
        if_to_ic_inst       = {INST_WIDTH{1'b0}};
        if_to_ic_inst_valid = 1'b0;
        if_to_mc_req        = 1'b0;
        if_to_mc_addr       = {ADDR_WIDTH{1'b0}};
        if (state_q == MEM_WAIT) begin
            if_to_ic_inst_addr  = miss_addr_q;
            if_to_mc_req        = 1'b1;
            if_to_mc_addr       = miss_addr_q;
            if_to_ic_inst_valid = refill_s;
            if (refill_s) begin
                if_to_ic_inst = mc_to_if_inst;
            end else begin
                if_to_ic_inst = {INST_WIDTH{1'b0}};
            end
        end else begin
            // Lookup is held off while reset is asserted so every output reads 0.
            if_to_ic_ready = rst_in;
        end
    end

    // Next-state: PC advance, miss capture, redirect and issue register.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        iq_valid_d  = iq_valid_q;
        iq_inst_d   = iq_inst_q;
        iq_pc_d     = iq_pc_q;
        if (rdy_in) begin
            iq_valid_d = 1'b0;
            if (clr_in) begin
                pc_d = clr_pc_aligned_s;
                // An outstanding memory request cannot be cancelled; wait it out.
                if ((state_q == MEM_WAIT) && !mc_to_if_done) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = FETCH;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        if (!ic_to_if_hit) begin
                            miss_addr_d = pc_q;
                            state_d     = MEM_WAIT;
                        end else if (!iq_to_if_full) begin
                            iq_valid_d = 1'b1;
                            iq_inst_d  = ic_to_if_hit_inst;
                            iq_pc_d    = pc_q;
                            pc_d       = pc_q + PC_STEP;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    MEM_WAIT: begin
                        if (mc_to_if_done) begin
                            state_d = FETCH;
                        end else begin
                            state_d = MEM_WAIT;
                        end
                    end
                    default: begin
                        state_d = FETCH;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and issue registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            miss_addr_q <= {ADDR_WIDTH{1'b0}};
            iq_valid_q  <= 1'b0;
            iq_inst_q   <= {INST_WIDTH{1'b0}};
            iq_pc_q     <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            iq_valid_q  <= iq_valid_d;
            iq_inst_q   <= iq_inst_d;
            iq_pc_q     <= iq_pc_d;
        end
    end

    assign if_to_iq_valid = iq_valid_q;
    assign if_to_iq_inst  = iq_inst_q;
    assign if_to_iq_pc    = iq_pc_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher with a small associative cache
// model and a scoreboard of expected queue issues.
module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic [31:0] clr_pc;
    logic [31:0] if_to_ic_inst_addr;
    logic [31:0] if_to_ic_inst;
    logic        if_to_ic_inst_valid;
    logic        if_to_ic_ready;
    logic        ic_to_if_hit;
    logic [31:0] ic_to_if_hit_inst;
    logic        if_to_mc_req;
    logic [31:0] if_to_mc_addr;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_inst;
    logic        iq_to_if_full;
    logic        if_to_iq_valid;
    logic [31:0] if_to_iq_inst;
    logic [31:0] if_to_iq_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] c_tag  [16];
    logic [31:0] c_data [16];
    logic [15:0] c_vld = 16'h0;
    int          c_ptr = 0;
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;

    instruction_fetcher dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc(clr_pc),
        .if_to_ic_inst_addr(if_to_ic_inst_addr), .if_to_ic_inst(if_to_ic_inst),
        .if_to_ic_inst_valid(if_to_ic_inst_valid), .if_to_ic_ready(if_to_ic_ready),
        .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
        .if_to_mc_req(if_to_mc_req), .if_to_mc_addr(if_to_mc_addr),
        .mc_to_if_done(mc_to_if_done), .mc_to_if_inst(mc_to_if_inst),
        .iq_to_if_full(iq_to_if_full), .if_to_iq_valid(if_to_iq_valid),
        .if_to_iq_inst(if_to_iq_inst), .if_to_iq_pc(if_to_iq_pc)
    );

    always #5 clk_in = ~clk_in;

    // Cache model storage: bench preloads and DUT refills.
    always @(posedge clk_in) begin
        if (pl_en) begin
            c_tag[c_ptr]  <= pl_addr;
            c_data[c_ptr] <= pl_data;
            c_vld[c_ptr]  <= 1'b1;
            c_ptr         <= (c_ptr + 1) % 16;
        end else if (if_to_ic_inst_valid) begin
            c_tag[c_ptr]  <= if_to_ic_inst_addr;
            c_data[c_ptr] <= if_to_ic_inst;
            c_vld[c_ptr]  <= 1'b1;
            c_ptr         <= (c_ptr + 1) % 16;
        end
    end

    // Cache model combinational lookup.
    always_comb begin
        ic_to_if_hit      = 1'b0;
        ic_to_if_hit_inst = 32'h0;
        for (int i = 0; i < 16; i++) begin
            if (if_to_ic_ready && c_vld[i] && (c_tag[i] == if_to_ic_inst_addr)) begin
                ic_to_if_hit      = 1'b1;
                ic_to_if_hit_inst = c_data[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    // Advance one cycle; every issue pulse is matched against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        #1;
        if (if_to_iq_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL iq_issue: got pc=%h inst=%h, required no issue", if_to_iq_pc, if_to_iq_inst);
            end else begin
                e = exp_q.pop_front();
                if (if_to_iq_pc !== e.pc || if_to_iq_inst !== e.inst) begin
                    errors++;
                    $display("FAIL iq_issue: got pc=%h inst=%h, required pc=%h inst=%h",
                             if_to_iq_pc, if_to_iq_inst, e.pc, e.inst);
                end
            end
        end
    endtask

    task automatic preload(input logic [31:0] a);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = inst_of(a);
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.pc   = a;
        e.inst = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        checks++;
        if ({if_to_ic_ready, if_to_ic_inst_valid, if_to_mc_req, if_to_iq_valid} !== 4'b0000 ||
            if_to_ic_inst_addr !== 32'h0 || if_to_mc_addr !== 32'h0 ||
            if_to_iq_pc !== 32'h0 || if_to_iq_inst !== 32'h0 || if_to_ic_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b ival=%b req=%b iqv=%b addr=%h, required all 0",
                     if_to_ic_ready, if_to_ic_inst_valid, if_to_mc_req, if_to_iq_valid, if_to_ic_inst_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), inst_of(32'(i * 4)));
        rst_in = 1'b1;
        tick();
        checks++;
        if (if_to_iq_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_pulse: valid=%b, required 1", if_to_iq_valid);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: %0d pending, required 0", exp_q.size());
        end
        clr_in = 1'b1;
        clr_pc = 32'h100;
        tick();
        clr_in = 1'b0;
        checks++;
        if (if_to_iq_valid !== 1'b0 || if_to_ic_inst_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_100: valid=%b addr=%h, required 0 and 00000100", if_to_iq_valid, if_to_ic_inst_addr);
        end
    endtask

    task automatic test_cold_miss();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_to_mc_req !== 1'b1 || if_to_mc_addr !== 32'h100 || if_to_ic_ready !== 1'b0) begin
                errors++;
                $display("FAIL miss_req: req=%b addr=%h ready=%b, required 1 00000100 0",
                         if_to_mc_req, if_to_mc_addr, if_to_ic_ready);
            end
            tick();
        end
        mc_to_if_done = 1'b1;
        mc_to_if_inst = 32'h00A00093;
        #1;
        checks++;
        if ({if_to_ic_inst_valid, if_to_ic_ready, if_to_mc_req} !== 3'b101 ||
            if_to_ic_inst_addr !== 32'h100 || if_to_ic_inst !== 32'h00A00093) begin
            errors++;
            $display("FAIL refill_strobe: ival=%b rdy=%b req=%b addr=%h inst=%h, required 1 0 1 00000100 00a00093",
                     if_to_ic_inst_valid, if_to_ic_ready, if_to_mc_req, if_to_ic_inst_addr, if_to_ic_inst);
        end
        push_exp(32'h100, 32'h00A00093);
        tick();
        mc_to_if_done = 1'b0;
        mc_to_if_inst = 32'h0;
        checks++;
        if (if_to_iq_valid !== 1'b0 || if_to_ic_ready !== 1'b1 || if_to_mc_req !== 1'b0 ||
            if_to_ic_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_done: valid=%b ready=%b req=%b ival=%b, required 0 1 0 0",
                     if_to_iq_valid, if_to_ic_ready, if_to_mc_req, if_to_ic_inst_valid);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL miss_issue_latency: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        clr_in = 1'b1;
        clr_pc = 32'h20;
        tick();
        clr_in        = 1'b0;
        iq_to_if_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_to_iq_valid !== 1'b0 || if_to_ic_inst_addr !== 32'h20) begin
                errors++;
                $display("FAIL stall_hold: valid=%b addr=%h, required 0 00000020", if_to_iq_valid, if_to_ic_inst_addr);
            end
        end
        iq_to_if_full = 1'b0;
        push_exp(32'h20, inst_of(32'h20));
        push_exp(32'h24, inst_of(32'h24));
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || if_to_ic_inst_addr !== 32'h28) begin
            errors++;
            $display("FAIL stall_release: pending=%0d addr=%h, required 0 00000028", exp_q.size(), if_to_ic_inst_addr);
        end
    endtask

    task automatic test_clear_fetch();
        clr_in = 1'b1;
        clr_pc = 32'h207;
        tick();
        clr_in = 1'b0;
        checks++;
        if (if_to_iq_valid !== 1'b0 || if_to_ic_inst_addr !== 32'h204) begin
            errors++;
            $display("FAIL clear_fetch: valid=%b addr=%h, required 0 00000204", if_to_iq_valid, if_to_ic_inst_addr);
        end
        push_exp(32'h204, inst_of(32'h204));
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clear_fetch_issue: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_clear_mem_wait();
        logic found;
        clr_in = 1'b1;
        clr_pc = 32'h300;
        tick();
        clr_in = 1'b0;
        tick();
        checks++;
        if (if_to_mc_req !== 1'b1 || if_to_mc_addr !== 32'h300 || if_to_ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL miss_300: req=%b addr=%h ready=%b, required 1 00000300 0", if_to_mc_req, if_to_mc_addr, if_to_ic_ready);
        end
        clr_in = 1'b1;
        clr_pc = 32'h40;
        tick();
        clr_in = 1'b0;
        checks++;
        if (if_to_mc_req !== 1'b1 || if_to_iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_wait: req=%b valid=%b, required 1 0", if_to_mc_req, if_to_iq_valid);
        end
        mc_to_if_done = 1'b1;
        mc_to_if_inst = 32'hCAFE0300;
        #1;
        checks++;
        if (if_to_ic_inst_valid !== 1'b1 || if_to_ic_inst_addr !== 32'h300 || if_to_ic_inst !== 32'hCAFE0300) begin
            errors++;
            $display("FAIL refill_300: ival=%b addr=%h inst=%h, required 1 00000300 cafe0300",
                     if_to_ic_inst_valid, if_to_ic_inst_addr, if_to_ic_inst);
        end
        tick();
        mc_to_if_done = 1'b0;
        mc_to_if_inst = 32'h0;
        checks++;
        if (if_to_ic_ready !== 1'b1 || if_to_ic_inst_addr !== 32'h40 || if_to_mc_req !== 1'b0) begin
            errors++;
            $display("FAIL resume_40: ready=%b addr=%h req=%b, required 1 00000040 0",
                     if_to_ic_ready, if_to_ic_inst_addr, if_to_mc_req);
        end
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (c_vld[i] && c_tag[i] == 32'h300 && c_data[i] == 32'hCAFE0300) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL cache_300: present=%b, required 1", found);
        end
    endtask

    task automatic test_rdy_freeze();
        tick();
        rdy_in        = 1'b0;
        mc_to_if_done = 1'b1;
        mc_to_if_inst = 32'h12345678;
        #1;
        checks++;
        if (if_to_ic_inst_valid !== 1'b0 || if_to_mc_req !== 1'b1) begin
            errors++;
            $display("FAIL freeze_done: ival=%b req=%b, required 0 1", if_to_ic_inst_valid, if_to_mc_req);
        end
        tick();
        tick();
        checks++;
        if (if_to_mc_req !== 1'b1 || if_to_mc_addr !== 32'h40 || if_to_ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: req=%b addr=%h ready=%b, required 1 00000040 0",
                     if_to_mc_req, if_to_mc_addr, if_to_ic_ready);
        end
        mc_to_if_done = 1'b0;
        mc_to_if_inst = 32'h0;
        rdy_in        = 1'b1;
    endtask

    task automatic test_reset_mid_miss();
        rst_in = 1'b0;
        #1;
        checks++;
        if (if_to_mc_req !== 1'b0 || if_to_ic_ready !== 1'b0 || if_to_ic_inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_miss: req=%b ready=%b addr=%h, required 0 0 00000000",
                     if_to_mc_req, if_to_ic_ready, if_to_ic_inst_addr);
        end
        tick();
        rst_in = 1'b1;
        push_exp(32'h0, inst_of(32'h0));
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_pc: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        clr_in = 1'b1;
        clr_pc = 32'hFFFF_FFFC;
        tick();
        clr_in = 1'b0;
        push_exp(32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC));
        tick();
        checks++;
        if (exp_q.size() != 0 || if_to_ic_inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: pending=%0d addr=%h, required 0 00000000", exp_q.size(), if_to_ic_inst_addr);
        end
    endtask

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        clr_in        = 1'b0;
        clr_pc        = 32'h0;
        mc_to_if_done = 1'b0;
        mc_to_if_inst = 32'h0;
        iq_to_if_full = 1'b0;
        pl_en         = 1'b0;
        pl_addr       = 32'h0;
        pl_data       = 32'h0;
        #2;
        test_reset();
        preload(32'h0);
        preload(32'h4);
        preload(32'h8);
        preload(32'hC);
        preload(32'h20);
        preload(32'h24);
        preload(32'h28);
        preload(32'h204);
        preload(32'hFFFF_FFFC);
        test_stream();
        test_cold_miss();
        test_stall();
        test_clear_fetch();
        test_clear_mem_wait();
        test_rdy_freeze();
        test_reset_mid_miss();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
